// File: rtl/alu_calc_core.sv
// Calculator datapath between the board switches/buttons and the 7-segment driver.
// The buttons are debounced and step a 3-bit operation selector up or down.
// The operands are synchronised, registered, and fed to a 2W-bit ALU that has status flags.
// res_upd pulses for one cycle whenever the registered result or flags change.
module alu_calc_core #(
   parameter int W       = 4,
   parameter int DB_CNT  = 500000,
   parameter int OP_INIT = 0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   data_a,
   input  logic [W-1:0]   data_b,
   input  logic           btn_next,
   input  logic           btn_prev,
   output logic [2:0]     op_sel,
   output logic [2*W-1:0] alu_out,
   output logic           flag_zero,
   output logic           flag_carry,
   output logic           flag_neg,
   output logic           res_upd
);

   localparam int W2 = 2 * W;
   localparam int CW = $clog2(DB_CNT);
   localparam logic [CW-1:0] DB_LOAD = CW'(DB_CNT - 1);

   logic [1:0]    rst_sync;
   logic          rst_n;
   logic [W-1:0]  a_m, a_s, b_m, b_s, a_q, b_q;
   logic [1:0]    btn_m, btn_s;
   logic [1:0]    db_acc, db_arm, db_tick;
   logic [CW-1:0] db_cnt [2];
   logic [2:0]    op_q;
   logic [W2-1:0] a_x, b_x, res_c;
   logic          c_c, n_c, lt, run_q;
   logic [W2+2:0] nxt_v, cur_v;

   // Reset asserts asynchronously and is released on a clock edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   // 2-FF synchronisers. Button stages reset to "pressed", so a button
   // held through reset is never mistaken for a released one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_m   <= '0;
         a_s   <= '0;
         b_m   <= '0;
         b_s   <= '0;
         btn_m <= '1;
         btn_s <= '1;
      end else begin
         a_m   <= data_a;
         a_s   <= a_m;
         b_m   <= data_b;
         b_s   <= b_m;
         btn_m <= {btn_prev, btn_next};
         btn_s <= btn_m;
      end
   end

   // Debounce: a down-counter runs while the synced level differs from the
   // accepted level. The accepted level flips at terminal count. A rising flip
   // ticks only after a released level has been seen since reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_acc  <= '0;
         db_arm  <= '0;
         db_tick <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= DB_LOAD;
      end else begin
         for (int i = 0; i < 2; i++) begin
            db_tick[i] <= 1'b0;
            if (!btn_s[i]) db_arm[i] <= 1'b1;
            if (btn_s[i] == db_acc[i]) begin
               db_cnt[i] <= DB_LOAD;
            end else if (db_cnt[i] == '0) begin
               db_acc[i]  <= btn_s[i];
               db_cnt[i]  <= DB_LOAD;
               db_tick[i] <= btn_s[i] & db_arm[i];
            end else begin
               db_cnt[i] <= db_cnt[i] - CW'(1);
            end
         end
      end
   end

   // Operation selector (also the stage-1 op register); simultaneous ticks cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= 3'(OP_INIT);
      end else begin
         case (db_tick)
            2'b01:   op_q <= op_q + 3'd1;
            2'b10:   op_q <= op_q - 3'd1;
            default: op_q <= op_q;
         endcase
      end
   end
   assign op_sel = op_q;

   // Stage 1: register the synchronised operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_s;
         b_q <= b_s;
      end
   end

   // ALU on the zero-extended stage-1 operands.
   always_comb begin
      a_x   = W2'(a_q);
      b_x   = W2'(b_q);
      lt    = (a_q < b_q);
      res_c = '0;
      c_c   = 1'b0;
      n_c   = 1'b0;
      case (op_q)
         3'd0: begin
            res_c = a_x + b_x;
            c_c   = res_c[W];
         end
         3'd1: begin
            res_c = a_x - b_x;
            c_c   = lt;
            n_c   = lt;
         end
         3'd2:    res_c = a_x * b_x;
         3'd3:    res_c = a_x & b_x;
         3'd4:    res_c = a_x | b_x;
         3'd5:    res_c = a_x ^ b_x;
         3'd6:    res_c = a_x << b_q;
         default: res_c = lt ? b_x : a_x;
      endcase
   end

   assign nxt_v = {res_c, (res_c == '0), c_c, n_c};
   assign cur_v = {alu_out, flag_zero, flag_carry, flag_neg};

   // Stage 2: result/flag registers. The change pulse is held off for the first
   // cycle after reset, when flag_zero settles from its cleared value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out    <= '0;
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
         flag_neg   <= 1'b0;
         res_upd    <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         alu_out    <= res_c;
         flag_zero  <= (res_c == '0);
         flag_carry <= c_c;
         flag_neg   <= n_c;
         run_q      <= 1'b1;
         res_upd    <= run_q && (nxt_v != cur_v);
      end
   end

endmodule
